ex_mem_access: RTL and testbench

EX_MEM_ACCESS -- requirements
Module: ex_mem_access

---
 rtl/mem_access_pkg.sv | 63 ++++++
 rtl/ex_mem_access_if.sv | 27 ++
 rtl/ex_mem_access_outst.sv | 53 +++++
 rtl/ex_mem_access.sv | 183 ++++++++++++++++++
 tb/tb_ex_mem_access.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the EX-stage memory access block:
// access-size encodings, FSM state encoding, strobe generation and
// alignment helpers.
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_STALL = 2'd2
   } state_e;

   // Widest supported bus is 64 bits, i.e. 8 byte lanes.
   localparam int unsigned MAX_LANES = 8;
   // Outstanding counters hold at most 7 entries.
   localparam int unsigned CNT_W     = 3;

   // Size mask for the access, shifted to the byte offset inside the bus word.
   function automatic logic [MAX_LANES-1:0] strb_gen(input logic [1:0] size,
                                                      input logic [2:0] off);
      logic [MAX_LANES-1:0] mask;
      case (size_e'(size))
         SZ_BYTE: mask = 8'h01;
         SZ_HALF: mask = 8'h03;
         SZ_WORD: mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask << off;
   endfunction

   // True when the low address bits are not a multiple of the access size.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [2:0] lo);
      logic mis;
      case (size_e'(size))
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lo[0];
         SZ_WORD: mis = |lo[1:0];
         default: mis = |lo;
      endcase
      return mis;
   endfunction

   // Clears the low address bits that must be zero for the access size.
   function automatic logic [2:0] align_lo(input logic [1:0] size,
                                           input logic [2:0] lo);
      logic [2:0] res;
      case (size_e'(size))
         SZ_BYTE: res = lo;
         SZ_HALF: res = {lo[2:1], 1'b0};
         SZ_WORD: res = {lo[2], 2'b00};
         default: res = 3'b000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ex_mem_access_if.sv
// Data-bus handshake between the EX-stage access block (master) and the
// memory side (slave). Signal names match the block's bus port names.
interface ex_mem_access_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic                  data_req_o;
   logic                  data_we_o;
   logic [1:0]            data_size_o;
   logic [DATA_W/8-1:0]   data_wstrb_o;
   logic [ADDR_W-1:0]     data_addr_o;
   logic [DATA_W-1:0]     data_wdata_o;
   logic                  data_addr_ok_i;
   logic                  data_data_ok_i;

   modport master (
      output data_req_o, data_we_o, data_size_o, data_wstrb_o,
             data_addr_o, data_wdata_o,
      input  data_addr_ok_i, data_data_ok_i
   );

   modport slave (
      input  data_req_o, data_we_o, data_size_o, data_wstrb_o,
             data_addr_o, data_wdata_o,
      output data_addr_ok_i, data_data_ok_i
   );
endinterface

// File: rtl/ex_mem_access_outst.sv
// Outstanding-request tracker: a live counter for requests whose responses
// are still wanted, and a discard counter for requests orphaned by a flush.
module mem_outst_tracker
   import mem_access_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             acc_i,
   input  logic             flush_i,
   input  logic             data_ok_i,
   output logic [CNT_W-1:0] live_cnt_o,
   output logic [CNT_W-1:0] total_o,
   output logic [CNT_W-1:0] total_nxt_o,
   output logic             resp_valid_o
);

   logic [CNT_W-1:0] live_q, live_d;
   logic [CNT_W-1:0] disc_q, disc_d;
   logic             dec_disc;
   logic             dec_live;

   // Responses retire discard entries first; a flush moves every live entry
   // (including one accepted in the same cycle) into the discard counter.
   always_comb begin
      dec_disc = data_ok_i && (disc_q != '0);
      dec_live = data_ok_i && (disc_q == '0) && (live_q != '0);
      live_d   = live_q - CNT_W'(dec_live);
      disc_d   = disc_q - CNT_W'(dec_disc);
      if (flush_i) begin
         disc_d = disc_d + live_d + CNT_W'(acc_i);
         live_d = '0;
      end else begin
         live_d = live_d + CNT_W'(acc_i);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q <= '0;
         disc_q <= '0;
      end else begin
         live_q <= live_d;
         disc_q <= disc_d;
      end
   end

   assign live_cnt_o   = live_q;
   assign total_o      = live_q + disc_q;
   assign total_nxt_o  = live_d + disc_d;
   assign resp_valid_o = dec_live;

endmodule

// File: rtl/ex_mem_access.sv
// EX-stage memory access block: turns an EX memory op into a registered
// bus request with lane-replicated data and byte strobes, limits the number
// of unanswered requests, and discards responses of flushed requests.
// Optional feature: define EX_MEM_ALE_CHECK_EN to raise ale_o on misaligned
// accesses; otherwise the low size-alignment address bits are forced to 0.
module ex_mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid_i,
   input  logic              ex_we_i,
   input  logic [1:0]        ex_size_i,
   input  logic [ADDR_W-1:0] ex_addr_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic              mem_allowin_i,
   input  logic              excep_flush_i,
   ex_mem_access_if.master   bus,
   output logic              ale_o,
   output logic              ex_ready_go_o,
   output logic              resp_valid_o,
   output logic [2:0]        outst_cnt_o
);

   localparam int unsigned      LANES   = DATA_W / 8;
   localparam int unsigned      OFF_W   = $clog2(LANES);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

   state_e              state_q, state_d;
   logic                req_we_q, req_we_d;
   logic [1:0]          req_size_q, req_size_d;
   logic [LANES-1:0]    req_wstrb_q, req_wstrb_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;

   logic                misaligned;
   logic [2:0]          addr_lo;
   logic [ADDR_W-1:0]   issue_addr;
   logic [MAX_LANES-1:0] strb_full;
   logic [LANES-1:0]    strb_now;
   logic [DATA_W-1:0]   wdata_rep;

   logic                mem_go;
   logic                capture;
   logic                acc;
   logic                ready_go;
   logic                in_req;
   logic                resp_valid;
   logic [CNT_W-1:0]    cnt_live;
   logic [CNT_W-1:0]    cnt_total;
   logic [CNT_W-1:0]    cnt_total_nxt;

   assign addr_lo = ex_addr_i[2:0];

`ifdef EX_MEM_ALE_CHECK_EN
   assign misaligned = is_misaligned(ex_size_i, addr_lo);
   assign issue_addr = ex_addr_i;
`else
   assign misaligned = 1'b0;
   assign issue_addr = {ex_addr_i[ADDR_W-1:3], align_lo(ex_size_i, addr_lo)};
`endif

   assign strb_full = strb_gen(ex_size_i, 3'(issue_addr[OFF_W-1:0]));
   assign strb_now  = strb_full[LANES-1:0];

   // Replicate the significant store bytes across every lane of the bus.
   always_comb begin
      wdata_rep = ex_wdata_i;
      case (size_e'(ex_size_i))
         SZ_BYTE: wdata_rep = {LANES{ex_wdata_i[7:0]}};
         SZ_HALF: wdata_rep = {(LANES/2){ex_wdata_i[15:0]}};
         SZ_WORD: wdata_rep = {(LANES/4){ex_wdata_i[31:0]}};
         default: wdata_rep = ex_wdata_i;
      endcase
   end

   // Next-state logic: issue when a slot is free, otherwise stall; STALL
   // looks at next cycle's count so a response frees the slot immediately.
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      acc      = 1'b0;
      ready_go = 1'b0;
      mem_go   = ex_valid_i && mem_allowin_i && !excep_flush_i && !misaligned;
      case (state_q)
         ST_IDLE: begin
            ready_go = ex_valid_i && misaligned;
            if (mem_go) begin
               if (cnt_total < MAX_CNT) begin
                  state_d = ST_REQ;
                  capture = 1'b1;
               end else begin
                  state_d = ST_STALL;
               end
            end
         end
         ST_REQ: begin
            if (bus.data_addr_ok_i) begin
               acc      = 1'b1;
               ready_go = ex_valid_i;
               state_d  = ST_IDLE;
            end else if (excep_flush_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_STALL: begin
            if (excep_flush_i || !ex_valid_i) begin
               state_d = ST_IDLE;
            end else if (cnt_total_nxt < MAX_CNT) begin
               state_d = ST_REQ;
               capture = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request copy is loaded on entry to REQ and held until accepted.
   always_comb begin
      req_we_d    = req_we_q;
      req_size_d  = req_size_q;
      req_wstrb_d = req_wstrb_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      if (capture) begin
         req_we_d    = ex_we_i;
         req_size_d  = ex_size_i;
         req_wstrb_d = strb_now;
         req_addr_d  = issue_addr;
         req_wdata_d = wdata_rep;
      end
   end

   // State and request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_we_q    <= 1'b0;
         req_size_q  <= '0;
         req_wstrb_q <= '0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         req_we_q    <= req_we_d;
         req_size_q  <= req_size_d;
         req_wstrb_q <= req_wstrb_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
      end
   end

   mem_outst_tracker u_tracker (
      .clk          (clk),
      .rst_n        (rst_n),
      .acc_i        (acc),
      .flush_i      (excep_flush_i),
      .data_ok_i    (bus.data_data_ok_i),
      .live_cnt_o   (cnt_live),
      .total_o      (cnt_total),
      .total_nxt_o  (cnt_total_nxt),
      .resp_valid_o (resp_valid)
   );

   assign in_req           = (state_q == ST_REQ);
   assign bus.data_req_o   = in_req;
   assign bus.data_we_o    = in_req & req_we_q;
   assign bus.data_size_o  = in_req ? req_size_q  : '0;
   assign bus.data_wstrb_o = in_req ? req_wstrb_q : '0;
   assign bus.data_addr_o  = in_req ? req_addr_q  : '0;
   assign bus.data_wdata_o = in_req ? req_wdata_q : '0;

   // Combinational outputs are held low while reset is asserted.
   assign ale_o         = rst_n & ex_valid_i & misaligned;
   assign ex_ready_go_o = rst_n & ready_go;
   assign resp_valid_o  = rst_n & resp_valid;
   assign outst_cnt_o   = cnt_live;

endmodule

// File: tb/tb_ex_mem_access.sv
// Bench for ex_mem_access: vector table, directed corner sequences and a
// randomized run against a behavioural model. Honours EX_MEM_ALE_CHECK_EN.
module tb_ex_mem_access;
   import mem_access_pkg::*;

`ifdef EX_MEM_ALE_CHECK_EN
   localparam bit ALE_ON = 1'b1;
`else
   localparam bit ALE_ON = 1'b0;
`endif
   localparam int MAXO = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        rst_n, ex_valid, ex_we, mem_allowin, flush;
   logic [1:0]  ex_size;
   logic [31:0] ex_addr, ex_wdata;
   logic        ale, ready_go, resp_valid;
   logic [2:0]  outst;
   ex_mem_access_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();

   ex_mem_access #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(MAXO)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_we_i(ex_we),
      .ex_size_i(ex_size), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
      .mem_allowin_i(mem_allowin), .excep_flush_i(flush), .bus(bus32),
      .ale_o(ale), .ex_ready_go_o(ready_go), .resp_valid_o(resp_valid),
      .outst_cnt_o(outst)
   );

   // 64-bit instance
   logic        rst64_n, v64, we64, allow64, flush64;
   logic [1:0]  sz64;
   logic [31:0] a64;
   logic [63:0] wd64;
   logic        ale64, rg64, rv64;
   logic [2:0]  oc64;
   ex_mem_access_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

   ex_mem_access #(.DATA_W(64), .ADDR_W(32), .MAX_OUTST(MAXO)) dut64 (
      .clk(clk), .rst_n(rst64_n), .ex_valid_i(v64), .ex_we_i(we64),
      .ex_size_i(sz64), .ex_addr_i(a64), .ex_wdata_i(wd64),
      .mem_allowin_i(allow64), .excep_flush_i(flush64), .bus(bus64),
      .ale_o(ale64), .ex_ready_go_o(rg64), .resp_valid_o(rv64),
      .outst_cnt_o(oc64)
   );

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
   } vec_t;
   vec_t vecs [6];

   // Reference helpers computed from the access rules with plain arithmetic.
   function automatic logic [31:0] ref_addr(input logic [1:0] sz, input logic [31:0] a);
      int unsigned bytes = 1 << sz;
      return ALE_ON ? a : (a - (a % bytes));
   endfunction

   function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [31:0] a);
      int unsigned bytes = 1 << sz;
      int unsigned m = ((1 << bytes) - 1) << (a % 4);
      return 4'(m);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
      if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
      int unsigned bytes = 1 << sz;
      return ALE_ON && ((a % bytes) != 0);
   endfunction

   task automatic idle_inputs();
      ex_valid = 1'b0; ex_we = 1'b0; ex_size = 2'd0; ex_addr = '0; ex_wdata = '0;
      mem_allowin = 1'b1; flush = 1'b0;
      bus32.data_addr_ok_i = 1'b0; bus32.data_data_ok_i = 1'b0;
   endtask

   // Present a word load, get it accepted, and leave inputs idle at a negedge.
   task automatic accept_load(input logic [31:0] a, input string tag);
      @(negedge clk);
      ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'd2; ex_addr = a;
      @(negedge clk);
      bus32.data_addr_ok_i = 1'b1;
      #1 chk({tag, "_ready"}, 64'(ready_go), 64'd1);
      @(negedge clk);
      ex_valid = 1'b0; bus32.data_addr_ok_i = 1'b0;
   endtask

   // Model state for the randomized run
   int          live_m, disc_m;
   bit          busy_m, blocked_m;
   logic        m_we;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_strb;
   bit          op_v;
   logic        op_we;
   logic [1:0]  op_sz;
   logic [31:0] op_a, op_d;

   task automatic model_capture();
      busy_m  = 1'b1;
      m_we    = op_we;
      m_size  = op_sz;
      m_addr  = ref_addr(op_sz, op_a);
      m_wdata = ref_wdata(op_sz, op_d);
      m_strb  = ref_strb(op_sz, m_addr);
   endtask

   initial begin
      bit mis, exp_rg, acc, aok, dok, allow, fl;
      int tot_pre;

      vecs[0] = '{1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB};
      vecs[1] = '{1'b1, 2'd1, 32'h0000_2002, 32'h0000_1234, 4'b1100, 32'h1234_1234};
      vecs[2] = '{1'b1, 2'd2, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, 2'd0, 32'h0000_4000, 32'hAA55_AA55, 4'b0001, 32'h5555_5555};
      vecs[4] = '{1'b1, 2'd1, 32'h0000_0000, 32'h1234_BEEF, 4'b0011, 32'hBEEF_BEEF};
      vecs[5] = '{1'b0, 2'd0, 32'h0000_1001, 32'h0000_00C3, 4'b0010, 32'hC3C3_C3C3};

      idle_inputs();
      rst64_n = 1'b0; v64 = 1'b0; we64 = 1'b0; allow64 = 1'b1; flush64 = 1'b0;
      sz64 = 2'd0; a64 = '0; wd64 = '0;
      bus64.data_addr_ok_i = 1'b0; bus64.data_data_ok_i = 1'b0;

      // Reset with inputs that would otherwise drive outputs
      rst_n = 1'b0;
      ex_valid = 1'b1; ex_size = 2'd2; ex_addr = 32'h1002;
      bus32.data_data_ok_i = 1'b1; bus32.data_addr_ok_i = 1'b1;
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_req",    64'(bus32.data_req_o),   64'd0);
      chk("rst_wstrb",  64'(bus32.data_wstrb_o), 64'd0);
      chk("rst_addr",   64'(bus32.data_addr_o),  64'd0);
      chk("rst_ale",    64'(ale),                64'd0);
      chk("rst_ready",  64'(ready_go),           64'd0);
      chk("rst_resp",   64'(resp_valid),         64'd0);
      chk("rst_outst",  64'(outst),              64'd0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;

      // Table of single store/load transactions
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ex_valid = 1'b1; ex_we = vecs[i].we; ex_size = vecs[i].size;
         ex_addr = vecs[i].addr; ex_wdata = vecs[i].wdata;
         #1 chk($sformatf("tbl%0d_idle_req", i), 64'(bus32.data_req_o), 64'd0);
         @(negedge clk);
         #1;
         chk($sformatf("tbl%0d_req", i),   64'(bus32.data_req_o),   64'd1);
         chk($sformatf("tbl%0d_we", i),    64'(bus32.data_we_o),    64'(vecs[i].we));
         chk($sformatf("tbl%0d_size", i),  64'(bus32.data_size_o),  64'(vecs[i].size));
         chk($sformatf("tbl%0d_addr", i),  64'(bus32.data_addr_o),  64'(vecs[i].addr));
         chk($sformatf("tbl%0d_strb", i),  64'(bus32.data_wstrb_o), 64'(vecs[i].exp_strb));
         chk($sformatf("tbl%0d_wdata", i), 64'(bus32.data_wdata_o), 64'(vecs[i].exp_wdata));
         chk($sformatf("tbl%0d_hold", i),  64'(ready_go),           64'd0);
         bus32.data_addr_ok_i = 1'b1;
         #1 chk($sformatf("tbl%0d_ready", i), 64'(ready_go), 64'd1);
         @(negedge clk);
         ex_valid = 1'b0; bus32.data_addr_ok_i = 1'b0; bus32.data_data_ok_i = 1'b1;
         #1;
         chk($sformatf("tbl%0d_resp", i),    64'(resp_valid),         64'd1);
         chk($sformatf("tbl%0d_req_off", i), 64'(bus32.data_req_o),   64'd0);
         @(negedge clk);
         bus32.data_data_ok_i = 1'b0;
      end

      // Misaligned word load: exception path with ALE, aligned issue without
      @(negedge clk);
      ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'd2; ex_addr = 32'h1002;
      #1;
      chk("ale_flag",  64'(ale),              64'(ALE_ON));
      chk("ale_ready", 64'(ready_go),         64'(ALE_ON));
      chk("ale_req0",  64'(bus32.data_req_o), 64'd0);
      @(negedge clk);
      #1;
      chk("ale_req1",  64'(bus32.data_req_o),  64'(!ALE_ON));
      chk("ale_addr",  64'(bus32.data_addr_o), ALE_ON ? 64'd0 : 64'h1000);
      bus32.data_addr_ok_i = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0; bus32.data_addr_ok_i = 1'b0;
      #1 chk("ale_outst", 64'(outst), 64'(!ALE_ON));
      bus32.data_data_ok_i = 1'b1;
      #1 chk("ale_resp", 64'(resp_valid), 64'(!ALE_ON));
      @(negedge clk);
      bus32.data_data_ok_i = 1'b0;
      #1 chk("ale_outst0", 64'(outst), 64'd0);

      // Outstanding limit: third op stalls until a response frees a slot
      accept_load(32'h100, "lim_a");
      accept_load(32'h104, "lim_b");
      #1 chk("lim_outst2", 64'(outst), 64'd2);
      ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'd2; ex_addr = 32'h200;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("lim_stall_req%0d", k),   64'(bus32.data_req_o), 64'd0);
         chk($sformatf("lim_stall_ready%0d", k), 64'(ready_go),         64'd0);
      end
      bus32.data_data_ok_i = 1'b1;
      #1 chk("lim_resp", 64'(resp_valid), 64'd1);
      @(negedge clk);
      bus32.data_data_ok_i = 1'b0;
      #1;
      chk("lim_req_now", 64'(bus32.data_req_o),  64'd1);
      chk("lim_addr",    64'(bus32.data_addr_o), 64'h200);
      chk("lim_outst1",  64'(outst),             64'd1);
      bus32.data_addr_ok_i = 1'b1;
      #1 chk("lim_ready", 64'(ready_go), 64'd1);
      @(negedge clk);
      ex_valid = 1'b0; bus32.data_addr_ok_i = 1'b0; bus32.data_data_ok_i = 1'b1;
      #1 chk("lim_outst2b", 64'(outst), 64'd2);
      @(negedge clk);
      @(negedge clk);
      bus32.data_data_ok_i = 1'b0;
      #1 chk("lim_drained", 64'(outst), 64'd0);

      // Flush with two accepted loads: their responses are discarded
      accept_load(32'h300, "fl_a");
      accept_load(32'h304, "fl_b");
      flush = 1'b1;
      #1 chk("fl_outst_pre", 64'(outst), 64'd2);
      @(negedge clk);
      flush = 1'b0;
      #1 chk("fl_outst0", 64'(outst), 64'd0);
      bus32.data_data_ok_i = 1'b1;
      #1 chk("fl_disc1", 64'(resp_valid), 64'd0);
      @(negedge clk);
      #1 chk("fl_disc2", 64'(resp_valid), 64'd0);
      @(negedge clk);
      bus32.data_data_ok_i = 1'b0;
      accept_load(32'h308, "fl_c");
      bus32.data_data_ok_i = 1'b1;
      #1 chk("fl_live_resp", 64'(resp_valid), 64'd1);
      @(negedge clk);
      bus32.data_data_ok_i = 1'b0;
      #1 chk("fl_outst_end", 64'(outst), 64'd0);

      // Flush in REQ without acceptance drops the request
      @(negedge clk);
      ex_valid = 1'b1; ex_we = 1'b1; ex_size = 2'd0; ex_addr = 32'h40;
      @(negedge clk);
      #1 chk("frq_req", 64'(bus32.data_req_o), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; ex_valid = 1'b0;
      #1;
      chk("frq_dropped", 64'(bus32.data_req_o), 64'd0);
      chk("frq_outst",   64'(outst),            64'd0);

      // Flush together with acceptance becomes a discard entry
      @(negedge clk);
      ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'd2; ex_addr = 32'h80;
      @(negedge clk);
      bus32.data_addr_ok_i = 1'b1; flush = 1'b1;
      #1 chk("fak_ready", 64'(ready_go), 64'd1);
      @(negedge clk);
      ex_valid = 1'b0; bus32.data_addr_ok_i = 1'b0; flush = 1'b0;
      #1 chk("fak_outst", 64'(outst), 64'd0);
      bus32.data_data_ok_i = 1'b1;
      #1 chk("fak_resp", 64'(resp_valid), 64'd0);
      @(negedge clk);
      #1 chk("fak_zero_resp", 64'(resp_valid), 64'd0);
      @(negedge clk);
      bus32.data_data_ok_i = 1'b0;

      // 64-bit bus: dword strobes, byte replication, async reset during REQ
      rst64_n = 1'b1;
      @(negedge clk);
      v64 = 1'b1; we64 = 1'b1; sz64 = 2'd3; a64 = 32'h8; wd64 = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      #1;
      chk("d64_req",   64'(bus64.data_req_o),   64'd1);
      chk("d64_strb",  64'(bus64.data_wstrb_o), 64'hFF);
      chk("d64_wdata", bus64.data_wdata_o,      64'h0123_4567_89AB_CDEF);
      chk("d64_addr",  64'(bus64.data_addr_o),  64'h8);
      rst64_n = 1'b0;
      #1;
      chk("d64_rst_req",  64'(bus64.data_req_o),   64'd0);
      chk("d64_rst_strb", 64'(bus64.data_wstrb_o), 64'd0);
      chk("d64_rst_ready", 64'(rg64),              64'd0);
      @(negedge clk);
      rst64_n = 1'b1; sz64 = 2'd0; a64 = 32'h5; wd64 = 64'h5A;
      @(negedge clk);
      #1;
      chk("d64b_strb",  64'(bus64.data_wstrb_o), 64'h20);
      chk("d64b_wdata", bus64.data_wdata_o,      64'h5A5A_5A5A_5A5A_5A5A);
      bus64.data_addr_ok_i = 1'b1;
      #1 chk("d64b_ready", 64'(rg64), 64'd1);
      @(negedge clk);
      v64 = 1'b0; bus64.data_addr_ok_i = 1'b0;
      #1 chk("d64b_outst", 64'(oc64), 64'd1);

      // Randomized run against the behavioural model
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      live_m = 0; disc_m = 0; busy_m = 1'b0; blocked_m = 1'b0; op_v = 1'b0;
      op_we = 1'b0; op_sz = 2'd0; op_a = '0; op_d = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!op_v && $urandom_range(0, 2) != 0) begin
            op_v  = 1'b1;
            op_we = 1'($urandom_range(0, 1));
            op_sz = 2'($urandom_range(0, 2));
            op_a  = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 1) == 0) op_a = op_a & 32'hFFFF_FFFC;
            op_d  = $urandom;
         end
         allow = ($urandom_range(0, 3) != 0);
         fl    = ($urandom_range(0, 15) == 0);
         aok   = ($urandom_range(0, 1) == 0);
         dok   = ($urandom_range(0, 2) == 0);
         ex_valid = op_v; ex_we = op_we; ex_size = op_sz; ex_addr = op_a; ex_wdata = op_d;
         mem_allowin = allow; flush = fl;
         bus32.data_addr_ok_i = aok; bus32.data_data_ok_i = dok;
         #1;
         mis    = op_v && ref_mis(op_sz, op_a);
         exp_rg = op_v && ((!busy_m && !blocked_m && mis) || (busy_m && aok));
         chk("rnd_req",   64'(bus32.data_req_o),   64'(busy_m));
         chk("rnd_we",    64'(bus32.data_we_o),    64'(busy_m && m_we));
         chk("rnd_size",  64'(bus32.data_size_o),  busy_m ? 64'(m_size)  : 64'd0);
         chk("rnd_addr",  64'(bus32.data_addr_o),  busy_m ? 64'(m_addr)  : 64'd0);
         chk("rnd_strb",  64'(bus32.data_wstrb_o), busy_m ? 64'(m_strb)  : 64'd0);
         chk("rnd_wdata", 64'(bus32.data_wdata_o), busy_m ? 64'(m_wdata) : 64'd0);
         chk("rnd_ale",   64'(ale),                64'(mis));
         chk("rnd_ready", 64'(ready_go),           64'(exp_rg));
         chk("rnd_resp",  64'(resp_valid),         64'(dok && disc_m == 0 && live_m > 0));
         chk("rnd_outst", 64'(outst),              64'(live_m));

         // Advance the model across the coming clock edge
         tot_pre = live_m + disc_m;
         acc = busy_m && aok;
         if (dok) begin
            if (disc_m > 0) disc_m--;
            else if (live_m > 0) live_m--;
         end
         if (fl) begin
            disc_m = disc_m + live_m + int'(acc);
            live_m = 0;
         end else begin
            live_m = live_m + int'(acc);
         end
         if (busy_m) begin
            if (aok || fl) busy_m = 1'b0;
         end else if (blocked_m) begin
            if (fl || !op_v) blocked_m = 1'b0;
            else if (live_m + disc_m < MAXO) begin
               blocked_m = 1'b0;
               model_capture();
            end
         end else if (op_v && allow && !fl && !mis) begin
            if (tot_pre < MAXO) model_capture();
            else blocked_m = 1'b1;
         end
         if (exp_rg || fl) op_v = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
